fir_decimator: RTL and testbench
================================

// Module: fir_decimator
// PURPOSE
//  Integrate-and-dump decimator placed directly downstream of the 3-tap FIR.
//  - Accumulates 2**LOG2_DECIM valid FIR output samples, then emits their mean.
//  - The mean goes out on a valid/ready interface.
//  - Reduces the FIR's per-clock output to one sample per DECIM inputs, for the
//    slower consumer that follows.
// PARAMETERS
//  DW          8   sample width; unsigned; matches the FIR o_y width
//  LOG2_DECIM  2   log2 of decimation ratio; DECIM = 2**LOG2_DECIM; legal range 0..6
// PORTS
//  clk       in   1                clock; all state on rising edge
//  rst_n     in   1                asynchronous, active-low reset
//  i_x       in   DW               FIR output sample (unsigned)
//  i_valid   in   1                i_x is valid this cycle
//  i_clr     in   1                synchronous clear of all state, including any pending output
//  o_y       out  DW               decimated sample
//  o_valid   out  1                o_y holds an untransferred result
//  i_ready   in   1                downstream accepts o_y this cycle
//  o_overrun out  1                sticky: a result was overwritten before transfer
// BEHAVIOUR
//  Reset: acc=0, cnt=0, o_y=0, o_valid=0, o_overrun=0.
//  Internal state:
//   - acc is DW+LOG2_DECIM bits wide; this width cannot overflow.
//   - cnt is LOG2_DECIM bits wide and counts 0..DECIM-1.
//  Each cycle with i_valid=1 and i_clr=0:
//   - cnt < DECIM-1: acc <= acc + i_x; cnt <= cnt + 1.
//   - cnt == DECIM-1 (dump):
//     - sum = acc + i_x; o_y <= sum >> LOG2_DECIM; o_valid <= 1.
//     - acc <= 0; cnt <= 0.
//  i_valid=0: acc and cnt hold. Gaps in i_valid are allowed anywhere.
//  Latency: o_valid rises 1 clk after the cycle carrying the DECIMth sample.
//  LOG2_DECIM=0: every valid sample dumps; o_y <= i_x after 1 clk.
//  Output handshake: a transfer occurs on the cycle with o_valid & i_ready.
//   - Transfer, no dump in the same cycle: o_valid <= 0.
//   - Transfer and dump in the same cycle: o_valid stays 1, o_y takes the new
//     result, no overrun.
//   - Dump while o_valid=1 and i_ready=0: o_y is overwritten, o_valid stays 1,
//     o_overrun <= 1.
//   - o_y is stable while o_valid=1 and i_ready=0, unless a dump overwrites it.
//  i_clr=1 takes priority over everything in that cycle:
//   - acc, cnt, o_valid and o_overrun go to 0; o_y holds.
//   - Any sample or dump in that cycle is discarded.
//  Reset asserted mid-accumulation: state returns immediately to reset values;
//  the partial sum is lost.
//  o_overrun clears only on rst_n or i_clr.
// CONFIGURATION
//  Macro FIR_DECIM_ROUND_EN:
//   - Defined: the dump adds 2**(LOG2_DECIM-1) to sum before the shift
//     (round half up). LOG2_DECIM=0 adds 0.
//     The result stays <= 2**DW-1, so no saturation is needed.
//   - Undefined: plain truncation (floor).
// STRUCTURE
//  Shared package fir_pkg holds:
//   - FIR_DW = 8 localparam, used as the DW default;
//   - sample_t = logic [FIR_DW-1:0];
//   - the LOG2_DECIM_MAX = 6 constant used by the parameter range check.
//  Sub-module decim_out_reg: one-entry output holding register with the
//  valid/ready and overrun logic.
//  Accumulator, counter and dump datapath stay in fir_decimator.
// TESTING (DW=8, LOG2_DECIM=2 unless stated)
//  1. Reset, then i_x=1,2,3,4 with i_valid=1 and i_ready=1 ->
//     o_valid=1 for one clk; o_y=2 truncating, 3 with FIR_DECIM_ROUND_EN.
//  2. Four samples of 255 with i_valid toggling 1,0,1,0,... ->
//     o_y=255; o_overrun=0; no dump before the 4th valid sample.
//  3. i_ready=0, two blocks of 4 samples of 10 then 20 ->
//     o_y=20, o_valid=1, o_overrun=1.
//     Then i_ready=1 -> o_valid drops after 1 clk; o_overrun stays 1.
//  4. Result pending (o_valid=1) and i_ready=1 in the same cycle as the next
//     dump (samples 4,4,4,4) -> o_valid stays 1, o_y=4, o_overrun=0.
//  5. i_clr pulsed after 3 samples, then 4 samples of 8 -> single result o_y=8.
//     Also: rst_n pulsed low mid-block -> all outputs 0 asynchronously.
//  6. LOG2_DECIM=0: i_x=7,9 on consecutive clks with i_ready=1 ->
//     o_y=7 then 9, each one clk later; o_valid stays high.

Source files
------------

// File: rtl/fir_pkg.sv
// fir_pkg: shared FIR sample width, sample type and decimator limits.
package fir_pkg;
   localparam int FIR_DW = 8;
   localparam int LOG2_DECIM_MAX = 6;
   typedef logic [FIR_DW-1:0] sample_t;
endpackage

// File: rtl/decim_out_reg.sv
// decim_out_reg: one-entry output holding register with valid/ready handshake and sticky overrun.
module decim_out_reg #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_clr,
   input  logic          i_load,
   input  logic [DW-1:0] i_d,
   input  logic          i_ready,
   output logic [DW-1:0] o_y,
   output logic          o_valid,
   output logic          o_overrun
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_y       <= '0;
         o_valid   <= 1'b0;
         o_overrun <= 1'b0;
      end else if (i_clr) begin
         o_valid   <= 1'b0;
         o_overrun <= 1'b0;
      end else begin
         if (i_load) o_y <= i_d;
         o_valid   <= i_load | (o_valid & ~i_ready);
         o_overrun <= o_overrun | (i_load & o_valid & ~i_ready);
      end
   end
endmodule

// File: rtl/fir_decimator.sv
// fir_decimator: integrate-and-dump mean of 2**LOG2_DECIM FIR samples on a valid/ready output.
// Define FIR_DECIM_ROUND_EN for round-half-up instead of truncation.
module fir_decimator
   import fir_pkg::*;
#(
   parameter int DW         = FIR_DW,
   parameter int LOG2_DECIM = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [DW-1:0] i_x,
   input  logic          i_valid,
   input  logic          i_clr,
   output logic [DW-1:0] o_y,
   output logic          o_valid,
   input  logic          i_ready,
   output logic          o_overrun
);
   localparam int AW    = DW + LOG2_DECIM;
   localparam int CW    = LOG2_DECIM > 0 ? LOG2_DECIM : 1;
   localparam int DECIM = 1 << LOG2_DECIM;
`ifdef FIR_DECIM_ROUND_EN
   localparam int RND = DECIM >> 1;
`else
   localparam int RND = 0;
`endif
   if (LOG2_DECIM < 0 || LOG2_DECIM > LOG2_DECIM_MAX) begin : g_bad_log2
      $error("fir_decimator: LOG2_DECIM out of range");
   end
   logic [AW-1:0] acc, acc_nxt, sum;
   logic [CW-1:0] cnt;
   logic          take, dump;
   logic [DW-1:0] mean;
   assign take    = i_valid & ~i_clr;
   assign dump    = take & (cnt == CW'(DECIM - 1));
   assign acc_nxt = acc + AW'(i_x);
   // rounding offset cannot carry out of AW: max sum is 2**AW - DECIM
   assign sum     = acc_nxt + AW'(RND);
   assign mean    = DW'(sum >> LOG2_DECIM);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
         cnt <= '0;
      end else if (i_clr) begin
         acc <= '0;
         cnt <= '0;
      end else if (take) begin
         acc <= dump ? '0 : acc_nxt;
         cnt <= dump ? '0 : cnt + CW'(1);
      end
   end
   decim_out_reg #(.DW(DW)) u_out (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_clr     (i_clr),
      .i_load    (dump),
      .i_d       (mean),
      .i_ready   (i_ready),
      .o_y       (o_y),
      .o_valid   (o_valid),
      .o_overrun (o_overrun)
   );
endmodule

// File: tb/tb_fir_decimator.sv
// tb_fir_decimator: directed and random checks of fir_decimator (DECIM=4 and DECIM=1) against a block-mean model.
module tb_fir_decimator;
`ifdef FIR_DECIM_ROUND_EN
   localparam bit RND = 1'b1;
`else
   localparam bit RND = 1'b0;
`endif
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] i_x = '0;
   logic       i_valid = 1'b0, i_clr = 1'b0, i_ready = 1'b0;
   logic [7:0] o_y, o_y0;
   logic       o_valid, o_overrun, o_valid0, o_overrun0;
   int         checks = 0, errors = 0;
   // model state per instance: 0 -> DECIM=4, 1 -> DECIM=1
   int         s[2], n[2], ey[2];
   bit         ev[2], eo[2];

   always #5 clk = ~clk;

   fir_decimator #(.DW(8), .LOG2_DECIM(2)) dut (
      .clk(clk), .rst_n(rst_n), .i_x(i_x), .i_valid(i_valid), .i_clr(i_clr),
      .o_y(o_y), .o_valid(o_valid), .i_ready(i_ready), .o_overrun(o_overrun)
   );
   fir_decimator #(.DW(8), .LOG2_DECIM(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .i_x(i_x), .i_valid(i_valid), .i_clr(i_clr),
      .o_y(o_y0), .o_valid(o_valid0), .i_ready(i_ready), .o_overrun(o_overrun0)
   );

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         s[k] = 0; n[k] = 0; ey[k] = 0; ev[k] = 0; eo[k] = 0;
      end
   endtask

   task automatic model_tick(int k);
      int  d = (k == 0) ? 4 : 1;
      bit  dmp = 0;
      int  res = 0;
      if (i_clr) begin
         s[k] = 0; n[k] = 0; ev[k] = 0; eo[k] = 0;
         return;
      end
      if (i_valid) begin
         s[k] += int'(i_x);
         n[k]++;
         if (n[k] == d) begin
            dmp = 1;
            res = (s[k] + (RND ? d / 2 : 0)) / d;
            s[k] = 0; n[k] = 0;
         end
      end
      if (dmp) begin
         if (ev[k] && !i_ready) eo[k] = 1;
         ey[k] = res;
         ev[k] = 1;
      end else if (ev[k] && i_ready) ev[k] = 0;
   endtask

   task automatic cyc(input logic v, input logic [7:0] x, input logic r, input logic c);
      i_valid = v; i_x = x; i_ready = r; i_clr = c;
      @(posedge clk);
      model_tick(0);
      model_tick(1);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_reset();
      #12;
      checks++;
      if ({o_valid, o_y, o_overrun, o_valid0, o_y0, o_overrun0} !== 19'd0) begin
         errors++;
         $display("FAIL reset got v=%b y=%0d ov=%b v0=%b y0=%0d ov0=%b exp all 0", o_valid, o_y, o_overrun, o_valid0, o_y0, o_overrun0);
      end
      @(negedge clk) rst_n = 1'b1;
   endtask

   task automatic test_basic();
      for (int i = 1; i <= 4; i++) begin
         cyc(1, 8'(i), 1, 0);
         checks++;
         if (o_valid !== (i == 4)) begin
            errors++;
            $display("FAIL basic_valid s%0d got %b exp %b", i, o_valid, i == 4);
         end
      end
      checks++;
      if (o_y !== (RND ? 8'd3 : 8'd2)) begin
         errors++;
         $display("FAIL basic_y got %0d exp %0d", o_y, RND ? 3 : 2);
      end
      cyc(0, 0, 1, 0);
      checks++;
      if (o_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_drop got %b exp 0", o_valid);
      end
   endtask

   task automatic test_gaps();
      for (int i = 0; i < 7; i++) begin
         cyc(i % 2 == 0, 8'd255, 1, 0);
         checks++;
         if (o_valid !== (i == 6)) begin
            errors++;
            $display("FAIL gaps_valid c%0d got %b exp %b", i, o_valid, i == 6);
         end
      end
      checks++;
      if ({o_y, o_overrun} !== {8'd255, 1'b0}) begin
         errors++;
         $display("FAIL gaps_y got y=%0d ov=%b exp y=255 ov=0", o_y, o_overrun);
      end
   endtask

   task automatic test_overrun();
      for (int i = 0; i < 8; i++) begin
         cyc(1, i < 4 ? 8'd10 : 8'd20, 0, 0);
         if (i >= 4 && i < 7) begin
            checks++;
            if ({o_valid, o_y} !== {1'b1, 8'd10}) begin
               errors++;
               $display("FAIL ovr_hold c%0d got v=%b y=%0d exp v=1 y=10", i, o_valid, o_y);
            end
         end
      end
      checks++;
      if ({o_valid, o_y, o_overrun} !== {1'b1, 8'd20, 1'b1}) begin
         errors++;
         $display("FAIL ovr_state got v=%b y=%0d ov=%b exp v=1 y=20 ov=1", o_valid, o_y, o_overrun);
      end
      cyc(0, 0, 1, 0);
      checks++;
      if ({o_valid, o_overrun} !== 2'b01) begin
         errors++;
         $display("FAIL ovr_drain got v=%b ov=%b exp v=0 ov=1", o_valid, o_overrun);
      end
   endtask

   task automatic test_back_to_back();
      cyc(0, 0, 0, 1);
      for (int i = 0; i < 4; i++) cyc(1, 8'd2, 0, 0);
      for (int i = 0; i < 4; i++) cyc(1, 8'd4, i == 3, 0);
      checks++;
      if ({o_valid, o_y, o_overrun} !== {1'b1, 8'd4, 1'b0}) begin
         errors++;
         $display("FAIL b2b got v=%b y=%0d ov=%b exp v=1 y=4 ov=0", o_valid, o_y, o_overrun);
      end
   endtask

   task automatic test_clear();
      cyc(0, 0, 1, 0);
      for (int i = 0; i < 3; i++) cyc(1, 8'd50, 1, 0);
      cyc(1, 8'd50, 1, 1);
      checks++;
      if ({o_valid, o_overrun} !== 2'b00) begin
         errors++;
         $display("FAIL clr_dump got v=%b ov=%b exp 0 0", o_valid, o_overrun);
      end
      for (int i = 0; i < 4; i++) begin
         cyc(1, 8'd8, 1, 0);
         checks++;
         if (o_valid !== (i == 3)) begin
            errors++;
            $display("FAIL clr_valid s%0d got %b exp %b", i, o_valid, i == 3);
         end
      end
      checks++;
      if (o_y !== 8'd8) begin
         errors++;
         $display("FAIL clr_y got %0d exp 8", o_y);
      end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 8; i++) cyc(1, 8'd8, 0, 0);
      cyc(1, 8'd200, 0, 0);
      cyc(1, 8'd200, 0, 0);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      checks++;
      if ({o_valid, o_y, o_overrun} !== 10'd0) begin
         errors++;
         $display("FAIL async_rst got v=%b y=%0d ov=%b exp all 0", o_valid, o_y, o_overrun);
      end
      @(negedge clk) rst_n = 1'b1;
      for (int i = 0; i < 4; i++) cyc(1, 8'd6, 1, 0);
      checks++;
      if ({o_valid, o_y, o_overrun} !== {1'b1, 8'd6, 1'b0}) begin
         errors++;
         $display("FAIL post_rst got v=%b y=%0d ov=%b exp v=1 y=6 ov=0", o_valid, o_y, o_overrun);
      end
   endtask

   task automatic test_decim1();
      cyc(0, 0, 1, 1);
      cyc(1, 8'd7, 1, 0);
      checks++;
      if ({o_valid0, o_y0} !== {1'b1, 8'd7}) begin
         errors++;
         $display("FAIL d1_first got v=%b y=%0d exp v=1 y=7", o_valid0, o_y0);
      end
      cyc(1, 8'd9, 1, 0);
      checks++;
      if ({o_valid0, o_y0, o_overrun0} !== {1'b1, 8'd9, 1'b0}) begin
         errors++;
         $display("FAIL d1_second got v=%b y=%0d ov=%b exp v=1 y=9 ov=0", o_valid0, o_y0, o_overrun0);
      end
   endtask

   task automatic test_random();
      cyc(0, 0, 1, 1);
      for (int i = 0; i < 400; i++) begin
         cyc($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 60) == 0);
         checks++;
         if ({o_valid, o_y, o_overrun} !== {ev[0], 8'(ey[0]), eo[0]}) begin
            errors++;
            $display("FAIL rnd4 c%0d got v=%b y=%0d ov=%b exp v=%b y=%0d ov=%b", i, o_valid, o_y, o_overrun, ev[0], ey[0], eo[0]);
         end
         checks++;
         if ({o_valid0, o_y0, o_overrun0} !== {ev[1], 8'(ey[1]), eo[1]}) begin
            errors++;
            $display("FAIL rnd1 c%0d got v=%b y=%0d ov=%b exp v=%b y=%0d ov=%b", i, o_valid0, o_y0, o_overrun0, ev[1], ey[1], eo[1]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_gaps();
      test_overrun();
      test_back_to_back();
      test_clear();
      test_async_reset();
      test_decim1();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
